// File: rtl/cpu_pkg.sv
// Shared widths and the loader FSM state type for the program-RAM UART loader.
package cpu_pkg;
  localparam int ADDR_W_DEF = 4;
  localparam int DATA_W_DEF = 8;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    DATA  = 3'd2,
    STOP  = 3'd3,
    WRITE = 3'd4
  } loader_state_t;
endpackage

// File: rtl/uart_rx_core.sv
// 8N1 receiver: synchroniser, baud/bit counters, shift register; byte_valid/byte_ferr pulse at the stop-bit sample.
// No backpressure: a byte is offered once, one cycle before the WRITE state.
module uart_rx_core import cpu_pkg::*; #(
  parameter int CLKS_PER_BIT = 868,
  parameter int DATA_W       = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enable,
  input  logic              uart_rx,
  output logic              busy,
  output logic              byte_valid,
  output logic [DATA_W-1:0] byte_data,
  output logic              byte_ferr
);
  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam int BIT_W = $clog2(DATA_W);
  localparam logic [CNT_W-1:0] HALF_M1  = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] FULL_M1  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(DATA_W - 1);

  loader_state_t     state, state_nxt;
  logic              rx_meta, rx_sync;
  logic              armed;
  logic              tick;
  logic [CNT_W-1:0]  cnt;
  logic [BIT_W-1:0]  bit_idx;
  logic [DATA_W-1:0] shreg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_meta <= 1'b1;
      rx_sync <= 1'b1;
    end else begin
      rx_meta <= uart_rx;
      rx_sync <= rx_meta;
    end
  end

  assign tick      = (state == START) ? (cnt == HALF_M1) : (cnt == FULL_M1);
  assign busy      = (state != IDLE);
  assign byte_data = shreg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    byte_valid = 1'b0;
    byte_ferr  = 1'b0;
    case (state)
      IDLE:  if (armed && !rx_sync) state_nxt = START;
      START: if (tick) state_nxt = rx_sync ? IDLE : DATA;
      DATA:  if (tick && bit_idx == LAST_BIT) state_nxt = STOP;
      STOP: begin
        if (tick) begin
          if (rx_sync) begin
            state_nxt  = WRITE;
            byte_valid = 1'b1;
          end else begin
            state_nxt = IDLE;
            byte_ferr = 1'b1;
          end
        end
      end
      WRITE:   state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    if (!enable) begin
      state_nxt  = IDLE;
      byte_valid = 1'b0;
      byte_ferr  = 1'b0;
    end
  end

  // armed needs the line seen high in IDLE, so a held break or a mid-byte abort cannot re-trigger a start.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt     <= '0;
      bit_idx <= '0;
      shreg   <= '0;
      armed   <= 1'b0;
    end else begin
      if (state == IDLE || tick) cnt <= '0;
      else                       cnt <= cnt + 1'b1;
      if (state == IDLE) begin
        bit_idx <= '0;
      end else if (state == DATA && tick) begin
        shreg   <= {rx_sync, shreg[DATA_W-1:1]};
        bit_idx <= bit_idx + 1'b1;
      end
      if (!enable || byte_ferr)       armed <= 1'b0;
      else if (state == IDLE && rx_sync) armed <= 1'b1;
    end
  end
endmodule

// File: rtl/ram_program_loader.sv
// Writes each received UART byte into the program RAM at a wrapping address; ram_write 1 cycle after stop sample.
// No backpressure: the RAM accepts one write per byte; enable low drops partial bytes and clears counter/flags.
module ram_program_loader import cpu_pkg::*; #(
  parameter int CLKS_PER_BIT = 868,
  parameter int ADDR_W       = ADDR_W_DEF,
  parameter int DATA_W       = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enable,
  input  logic              uart_rx,
  output logic [ADDR_W-1:0] ram_address,
  output logic [DATA_W-1:0] ram_data,
  output logic              ram_write,
  output logic              busy,
  output logic              done,
  output logic              frame_error
);
  localparam logic [ADDR_W-1:0] LAST_ADDR = '1;

  logic              byte_valid;
  logic              byte_ferr;
  logic [DATA_W-1:0] byte_data;
  logic [ADDR_W-1:0] count;

  uart_rx_core #(
    .CLKS_PER_BIT(CLKS_PER_BIT),
    .DATA_W      (DATA_W)
  ) u_rx (
    .clk       (clk),
    .rst       (rst),
    .enable    (enable),
    .uart_rx   (uart_rx),
    .busy      (busy),
    .byte_valid(byte_valid),
    .byte_data (byte_data),
    .byte_ferr (byte_ferr)
  );

  // Address/data are captured on entry to WRITE so they hold until the next write,
  // while the counter advances only after the write cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ram_address <= '0;
      ram_data    <= '0;
      ram_write   <= 1'b0;
      count       <= '0;
      done        <= 1'b0;
      frame_error <= 1'b0;
    end else begin
      ram_write <= byte_valid;
      if (byte_valid) begin
        ram_address <= count;
        ram_data    <= byte_data;
        if (count == LAST_ADDR) done <= 1'b1;
      end
      if (ram_write) count <= count + 1'b1;
      if (byte_ferr) frame_error <= 1'b1;
      if (!enable) begin
        ram_write   <= 1'b0;
        count       <= '0;
        done        <= 1'b0;
        frame_error <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_ram_program_loader.sv
// Random and directed UART frames into the loader; writes are scoreboarded against an address/data model.
module tb_ram_program_loader;
  localparam int CPB = 4;

  logic       clk = 1'b0;
  logic       rst, enable, uart_rx;
  logic [3:0] ram_address;
  logic [7:0] ram_data;
  logic       ram_write, busy, done, frame_error;

  int vectors = 0;
  int miscompares = 0;

  logic [11:0] exp_q[$];
  int          exp_addr;
  int          exp_written;
  bit          exp_ferr;

  ram_program_loader #(.CLKS_PER_BIT(CPB), .ADDR_W(4), .DATA_W(8)) dut (
    .clk(clk), .rst(rst), .enable(enable), .uart_rx(uart_rx),
    .ram_address(ram_address), .ram_data(ram_data), .ram_write(ram_write),
    .busy(busy), .done(done), .frame_error(frame_error)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (ram_write === 1'b1) begin
      vectors++;
      if (exp_q.size() == 0) begin
        miscompares++;
        $display("FAIL unexpected_write: addr %0h data %0h", ram_address, ram_data);
      end else begin
        logic [11:0] e;
        e = exp_q.pop_front();
        if ({ram_address, ram_data} !== e) begin
          miscompares++;
          $display("FAIL write: got addr %0h data %0h expected addr %0h data %0h",
                   ram_address, ram_data, e[11:8], e[7:0]);
        end
      end
    end
  end

  function automatic void model_clear();
    exp_addr    = 0;
    exp_written = 0;
    exp_ferr    = 0;
  endfunction

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drive_bits(input logic [7:0] d, input int nbits);
    uart_rx = 1'b0;
    cycles(CPB);
    for (int i = 0; i < nbits; i++) begin
      uart_rx = d[i];
      cycles(CPB);
    end
  endtask

  // The model decides the outcome of a frame from the stop bit alone.
  task automatic send_byte(input logic [7:0] d, input logic stop_bit);
    if (enable && stop_bit) begin
      exp_q.push_back({4'(exp_addr), d});
      exp_addr = (exp_addr + 1) % 16;
      exp_written++;
    end else if (enable) begin
      exp_ferr = 1;
    end
    drive_bits(d, 8);
    uart_rx = stop_bit;
    cycles(CPB);
    uart_rx = 1'b1;
    cycles(3 * CPB);
  endtask

  task automatic clear_enable();
    enable = 1'b0;
    cycles(1);
    enable = 1'b1;
    model_clear();
    cycles(CPB);
  endtask

  task automatic check_flags(input string tag);
    chk({tag, "_done"}, done, exp_written >= 16);
    chk({tag, "_ferr"}, frame_error, exp_ferr);
    chk({tag, "_pending"}, exp_q.size(), 0);
  endtask

  initial begin
    rst = 1'b1; enable = 1'b1; uart_rx = 1'b1;
    model_clear();
    cycles(3);
    chk("rst_addr", ram_address, 0);
    chk("rst_data", ram_data, 0);
    chk("rst_flags", {ram_write, busy, done, frame_error}, 0);
    rst = 1'b0;
    cycles(2 * CPB);

    // 1: single byte
    send_byte(8'h50, 1'b1);
    chk("t1_busy", busy, 0);
    chk("t1_data_hold", ram_data, 8'h50);
    check_flags("t1");

    // 2: full program, then wrap
    clear_enable();
    for (int i = 0; i < 16; i++) begin
      send_byte(8'(i), 1'b1);
      chk("t2_done_prog", done, i == 15);
    end
    send_byte(8'hAA, 1'b1);
    chk("t2_wrap_addr", ram_address, 0);
    check_flags("t2");

    // 3: bad stop bit, counter unchanged, then enable pulse clears the flag
    clear_enable();
    send_byte(8'h11, 1'b1);
    send_byte(8'h3C, 1'b0);
    chk("t3_ferr_set", frame_error, 1);
    send_byte(8'h5A, 1'b1);
    check_flags("t3");
    clear_enable();
    chk("t3_ferr_clr", frame_error, 0);

    // 4: one-cycle glitch
    uart_rx = 1'b0;
    cycles(1);
    uart_rx = 1'b1;
    cycles(3 * CPB);
    chk("t4_busy", busy, 0);
    check_flags("t4");

    // 5: reset during data bit 4
    drive_bits(8'hF0, 4);
    uart_rx = 1'b1;
    cycles(CPB / 2);
    chk("t5_busy_before", busy, 1);
    rst = 1'b1;
    #1;
    chk("t5_rst_addr", ram_address, 0);
    chk("t5_rst_data", ram_data, 0);
    chk("t5_rst_flags", {ram_write, busy, done, frame_error}, 0);
    cycles(2);
    rst = 1'b0;
    model_clear();
    cycles(3 * CPB);
    send_byte(8'h81, 1'b1);
    check_flags("t5");

    // 6: enable dropped mid-byte
    send_byte(8'h22, 1'b1);
    drive_bits(8'h6B, 3);
    enable = 1'b0;
    uart_rx = 1'b1;
    cycles(2);
    chk("t6_busy", busy, 0);
    chk("t6_done", done, 0);
    enable = 1'b1;
    model_clear();
    cycles(3 * CPB);
    send_byte(8'h99, 1'b1);
    chk("t6_addr", ram_address, 0);
    check_flags("t6");

    // Random bytes with occasional framing errors and random gaps
    clear_enable();
    for (int n = 0; n < 40; n++) begin
      send_byte(8'($urandom), ($urandom_range(0, 7) != 0));
      cycles($urandom_range(0, 10));
    end
    check_flags("rand");

    cycles(10);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
